// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the iteration-counter width helper.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP   = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle on magnitudes, with sign correction in a final FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic               add_cin;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step_next;

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // Divide subtracts from the left-shifted partial remainder; bit WIDTH of the
  // difference is the borrow, since that remainder is always below twice the divisor.
  always_comb begin
    if (is_div) begin
      add_a   = acc[2*WIDTH-1:WIDTH-1];
      add_b   = ~{1'b0, opd};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc[2*WIDTH-1:WIDTH]};
      add_b   = {1'b0, opd};
      add_cin = 1'b0;
    end
    sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};

    if (is_div) begin
      if (sum[WIDTH]) begin
        step_next = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
        step_next = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      if (acc[0]) begin
        step_next = {sum, acc[WIDTH-1:1]};
      end else begin
        step_next = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod_neg = ~acc + (2*WIDTH)'(1);
    if (div_zero) begin
      quo_fix = '1;
    end else if (neg_lo) begin
      quo_fix = ~acc[WIDTH-1:0] + WIDTH'(1);
    end else begin
      quo_fix = acc[WIDTH-1:0];
    end
    rem_fix = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc[2*WIDTH-1:WIDTH];
  end

  // Remainder takes the dividend's sign, so a zero divisor leaves hi equal to a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc      <= '0;
      opd      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              case (op_e'(op))
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  acc      <= {{WIDTH{1'b0}}, a_mag};
                  opd      <= b_mag;
                  is_div   <= op[1];
                  neg_lo   <= a_neg ^ b_neg;
                  neg_hi   <= a_neg;
                  div_zero <= op[1] & (b == '0);
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= ST_RUN;
                end
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                default: ;
              endcase
            end
          end
          ST_RUN: begin
            acc <= step_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state <= ST_FIX;
            end
          end
          ST_FIX: begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else if (neg_lo) begin
              hi <= prod_neg[2*WIDTH-1:WIDTH];
              lo <= prod_neg[WIDTH-1:0];
            end else begin
              hi <= acc[2*WIDTH-1:WIDTH];
              lo <= acc[WIDTH-1:0];
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed MULT/DIV/MTxx vectors, latency,
// flush and asynchronous reset behaviour at WIDTH=32.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           checks = 0;
  int           errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;
  logic [W-1:0]   lo_before;
  int             done_edge;
  int             busy_cycles;
  bit             seen;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one request so that the next rising edge is its capture edge.
  task automatic applyStimulus(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                               input bit expect_done, input logic [2*W-1:0] expected);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_done) exp_q.push_back(expected);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d pending results required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n && done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done=1 required done=0");
          end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("result_hi", hi, mon_exp[2*W-1:W]);
            checkOutput("result_lo", lo, mon_exp[W-1:0]);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    checkOutput("reset_hi", hi, '0);
    checkOutput("reset_lo", lo, '0);
    checkOutput("reset_busy", W'(busy), '0);
    checkOutput("reset_done", W'(done), '0);

    // Release reset and start on the very first rising edge.
    rst_n = 1'b1;
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    done_edge   = 0;
    busy_cycles = 0;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_edge = e;
        break;
      end
      @(posedge clk);
    end
    checkOutput("multu_done_edge", W'(done_edge), 32'd34);
    checkOutput("multu_busy_cycles", W'(busy_cycles), 32'd33);
    waitIdle("multu", 10);

    @(negedge clk);
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    waitIdle("mult_neg", 60);
    @(negedge clk);
    applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    waitIdle("mult_minmin", 60);
    @(negedge clk);
    applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    waitIdle("mult_m1m1", 60);
    @(negedge clk);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    waitIdle("div_neg", 60);
    @(negedge clk);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
    waitIdle("div_overflow", 60);
    @(negedge clk);
    applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h0000_0001_FFFF_FFFD);
    waitIdle("div_negdivisor", 60);
    @(negedge clk);
    applyStimulus(OP_DIVU, 32'h1234, 32'd0, 1'b1, 64'h0000_1234_FFFF_FFFF);
    waitIdle("divu_zero", 60);
    @(negedge clk);
    applyStimulus(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1, 64'hFFFF_FFFB_FFFF_FFFF);
    waitIdle("div_zero", 60);

    // A new start is issued in the very cycle done is high.
    @(negedge clk);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1, 64'h0000_0002_0000_000E);
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    checkOutput("b2b_done_seen", W'(seen), 32'd1);
    applyStimulus(OP_MULTU, 32'h8000_0000, 32'd2, 1'b1, 64'h0000_0001_0000_0000);
    @(negedge clk);
    checkOutput("done_one_cycle", W'(done), '0);
    checkOutput("b2b_busy", W'(busy), 32'd1);
    waitIdle("b2b", 60);

    @(negedge clk);
    applyStimulus(OP_MTLO, 32'h0000_005A, 32'd0, 1'b0, '0);
    @(negedge clk);
    checkOutput("mtlo_lo", lo, 32'h5A);
    checkOutput("mtlo_busy", W'(busy), '0);
    applyStimulus(OP_MTHI, 32'h0000_00A5, 32'd0, 1'b0, '0);
    @(negedge clk);
    checkOutput("mthi_hi", hi, 32'hA5);
    checkOutput("mthi_done", W'(done), '0);
    lo_before = lo;

    // DIVU captured at edge 1, an MTLO start held over edges 2-9, flush at edge 10.
    applyStimulus(OP_DIVU, 32'h1000, 32'd3, 1'b0, '0);
    start = 1'b1;
    op    = OP_MTLO;
    a     = 32'h77;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("run_busy", W'(busy), 32'd1);
    checkOutput("run_start_ignored", lo, lo_before);
    start = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush_busy", W'(busy), '0);
    checkOutput("flush_done", W'(done), '0);
    checkOutput("flush_hi", hi, 32'hA5);
    checkOutput("flush_lo", lo, lo_before);
    repeat (40) @(negedge clk);
    checkOutput("flush_no_done_busy", W'(busy), '0);

    // Asynchronous reset in the middle of a MULT.
    applyStimulus(OP_MULT, 32'd5, 32'd6, 1'b0, '0);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_hi", hi, '0);
    checkOutput("arst_lo", lo, '0);
    checkOutput("arst_busy", W'(busy), '0);
    checkOutput("arst_done", W'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_MULTU, 32'd3, 32'd5, 1'b1, 64'h0000_0000_0000_000F);
    waitIdle("post_reset", 60);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The parameter WIDTH SHALL default to 32 and set the operand and result width; legal values are even and >= 4.
REQ-002 Port clk SHALL be an input of width 1 and is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input of width 1, asynchronous and active-low.
REQ-004 Port start SHALL be an input of width 1 that requests an operation in the current cycle.
REQ-005 Port op SHALL be an input of width 3 that selects the operation, sampled with start.
REQ-006 Port a SHALL be an input of width WIDTH carrying operand rs (dividend or multiplicand).
REQ-007 Port b SHALL be an input of width WIDTH carrying operand rt (divisor or multiplier).
REQ-008 Port flush SHALL be an input of width 1 that cancels any operation in flight.
REQ-009 Port busy SHALL be an output of width 1, high while an iterative operation is in progress.
REQ-010 Port done SHALL be an output of width 1 that gives a one-cycle pulse when hi and lo hold a new MULT or DIV result.
REQ-011 Port hi SHALL be an output of width WIDTH carrying the registered HI value.
REQ-012 Port lo SHALL be an output of width WIDTH carrying the registered LO value.

Function
REQ-013 The op encodings SHALL be: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 NOP.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and FIX.
REQ-015 start SHALL be accepted only in IDLE with flush low; a start seen in RUN or FIX SHALL be ignored.
REQ-016 An accepted MTHI or MTLO SHALL write a to hi or lo at the capture edge, with no busy and no done; NOP SHALL have no effect.
REQ-017 An accepted op 0-3 SHALL latch operand magnitudes and sign flags, move to RUN, clear the iteration counter and raise busy after the capture edge.
REQ-018 RUN SHALL perform exactly one iteration per cycle for WIDTH cycles: a shift-add step for multiply or a restoring subtract-shift step for divide.
REQ-019 After the WIDTH-th iteration the FSM SHALL enter FIX, which applies sign correction for one cycle and then writes hi/lo, returns to IDLE, clears busy and sets done.
REQ-020 Latency SHALL be: done high and hi/lo valid in the cycle that follows edge WIDTH+2, counting the capture edge as edge 1; for WIDTH=32 that is edge 34.
REQ-021 Multiply results SHALL be: {hi,lo} = the 2*WIDTH-bit product, signed for MULT and unsigned for MULTU.
REQ-022 Divide results SHALL be: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend (DIV) or unsigned (DIVU).
REQ-023 Divide by zero SHALL give lo = all ones and hi = a, with no exception raised.
REQ-024 Signed DIV of most-negative by -1 SHALL give lo = most-negative and hi = 0.
REQ-025 flush SHALL return the FSM to IDLE at the next edge, leave hi/lo unchanged and suppress done; flush takes priority over a simultaneous start.
REQ-026 done SHALL deassert at the following edge, and a new start SHALL be accepted in the same cycle that done is high.

Reset
REQ-027 rst_n low SHALL immediately force state to IDLE and busy, done, hi, lo, the counter and all internal datapath registers to 0, including during RUN or FIX.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-029 The package muldiv_pkg SHALL hold the op encodings, the state encodings and the counter-width function clog2(WIDTH)+1.
REQ-030 The datapath SHALL use a single shared WIDTH+1-bit adder/subtractor and a 2*WIDTH-bit shift register; no sub-module is required and the sign fix-up is inline.

Verification (WIDTH=32)
REQ-031 MULTU with a=0xFFFFFFFF and b=0xFFFFFFFF SHALL give hi=0xFFFFFFFE and lo=0x00000001, with done at edge 34 and busy high for exactly 33 cycles.
REQ-032 MULT with a=0xFFFFFFFD and b=7 SHALL give hi=0xFFFFFFFF and lo=0xFFFFFFEB.
REQ-033 DIV with a=0xFFFFFFF9 and b=2 SHALL give lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIV with a=0x80000000 and b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-034 DIVU with a=0x1234 and b=0 SHALL give lo=0xFFFFFFFF and hi=0x1234.
REQ-035 MTHI 0xA5, then DIVU started, then flush at edge 10, SHALL give hi=0xA5 retained, no done, busy low after edge 10, and a start held during edges 2-9 ignored.
REQ-036 rst_n pulsed low at edge 20 of a MULT SHALL give hi=lo=0 and busy=done=0 asynchronously, and a new MULTU 3*5 SHALL then give lo=15 and hi=0.
